// File: rtl/ltc2315_sdo_emulator_if.sv
// ltc2315_sdo_emulator_if: serial pins between an ADC master and the emulator.
//   cs_n   : chip select from the master, low while a frame is active
//   sck    : serial clock from the master
//   sdo    : serial data returned to the master
//   sdo_oe : pad output enable for sdo (1 = drive)
interface ltc2315_sdo_emulator_if;
    logic cs_n;
    logic sck;
    logic sdo;
    logic sdo_oe;

    modport master (
        output cs_n,
        output sck,
        input  sdo,
        input  sdo_oe
    );

    modport slave (
        input  cs_n,
        input  sck,
        output sdo,
        output sdo_oe
    );
endinterface

// File: rtl/ltc2315_sdo_emulator.sv
// ltc2315_sdo_emulator: behaves like the SDO side of a 12-bit LTC2315 ADC.
// A frame opens on a cs_n fall, drives one leading zero followed by the
// 12-bit sample MSB-first (one bit per sck fall), then zeros. Closing the
// frame with at least 12 sck falls counts it as valid, otherwise as aborted.
//   clk         : system clock, all logic on its rising edge
//   reset       : synchronous active-high reset
//   spi         : cs_n/sck in, sdo/sdo_oe out (both inputs asynchronous to clk)
//   mode        : sample source, 00 constant, 01 ramp, 10 loaded, 11 constant
//   sample_in   : value for loaded mode
//   sample_wr   : one-cycle strobe writing sample_in into the load register
//   frame_done  : one-cycle pulse for a valid completed frame
//   frame_err   : one-cycle pulse for an aborted frame
//   frame_count : number of valid frames, wraps at 16 bits
module ltc2315_sdo_emulator #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [11:0] RAMP_STEP   = 12'd1,
    parameter logic [11:0] CONST_VAL   = 12'h800
) (
    input  logic                         clk,
    input  logic                         reset,
    ltc2315_sdo_emulator_if.slave        spi,
    input  logic [1:0]                   mode,
    input  logic [11:0]                  sample_in,
    input  logic                         sample_wr,
    output logic                         frame_done,
    output logic                         frame_err,
    output logic [15:0]                  frame_count
);

    localparam int unsigned SAMPLE_W = 12;
    localparam int unsigned CNT_W    = 4;
    localparam int unsigned COUNT_W  = 16;
    localparam int unsigned N_BITS   = 12;
    localparam int unsigned CNT_MAX  = 15;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        TAIL  = 2'd2
    } state_t;

    // Synchronizers and edge-detect flops, reset to the idle (high) level
    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] sck_sync;
    logic                   cs_prev;
    logic                   sck_prev;

    logic cs_fall;
    logic cs_rise;
    logic sck_fall;

    state_t              state, state_d;
    logic [SAMPLE_W-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]    fall_cnt, fall_cnt_d;
    logic [SAMPLE_W-1:0] ramp_q, ramp_d;
    logic [SAMPLE_W-1:0] load_q, load_d;
    logic [COUNT_W-1:0]  frame_count_d;
    logic                sdo_q, sdo_d;
    logic                sdo_oe_q, sdo_oe_d;
    logic                frame_done_d;
    logic                frame_err_d;
    logic [SAMPLE_W-1:0] frame_sample;

    always_ff @(posedge clk) begin
        if (reset) begin
            cs_sync  <= '1;
            sck_sync <= '1;
            cs_prev  <= 1'b1;
            sck_prev <= 1'b1;
        end else begin
            cs_sync  <= {cs_sync[SYNC_STAGES-2:0], spi.cs_n};
            sck_sync <= {sck_sync[SYNC_STAGES-2:0], spi.sck};
            cs_prev  <= cs_sync[SYNC_STAGES-1];
            sck_prev <= sck_sync[SYNC_STAGES-1];
        end
    end

    assign cs_fall  =  cs_prev  & ~cs_sync[SYNC_STAGES-1];
    assign cs_rise  = ~cs_prev  &  cs_sync[SYNC_STAGES-1];
    assign sck_fall =  sck_prev & ~sck_sync[SYNC_STAGES-1];

    // Sample source; load_d already carries sample_in on a coinciding write
    always_comb begin
        frame_sample = CONST_VAL;
        case (mode)
            2'b01:   frame_sample = ramp_q;
            2'b10:   frame_sample = load_d;
            default: frame_sample = CONST_VAL;
        endcase
    end

    // Next-state and datapath decode
    always_comb begin
        state_d       = state;
        shift_d       = shift_q;
        fall_cnt_d    = fall_cnt;
        ramp_d        = ramp_q;
        frame_count_d = frame_count;
        sdo_d         = sdo_q;
        sdo_oe_d      = sdo_oe_q;
        frame_done_d  = 1'b0;
        frame_err_d   = 1'b0;
        load_d        = sample_wr ? sample_in : load_q;

        case (state)
            IDLE: begin
                sdo_d    = 1'b0;
                sdo_oe_d = 1'b0;
                if (cs_fall) begin
                    shift_d    = frame_sample;
                    fall_cnt_d = '0;
                    sdo_oe_d   = 1'b1;
                    state_d    = SHIFT;
                end
            end
            SHIFT, TAIL: begin
                // cs rise wins over a simultaneous sck fall
                if (cs_rise) begin
                    state_d  = IDLE;
                    sdo_d    = 1'b0;
                    sdo_oe_d = 1'b0;
                    if (fall_cnt >= CNT_W'(N_BITS)) begin
                        frame_done_d  = 1'b1;
                        frame_count_d = frame_count + COUNT_W'(1);
                        ramp_d        = ramp_q + RAMP_STEP;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end else if (sck_fall) begin
                    if (fall_cnt != CNT_W'(CNT_MAX)) begin
                        fall_cnt_d = fall_cnt + CNT_W'(1);
                    end
                    if (state == SHIFT) begin
                        sdo_d   = shift_q[SAMPLE_W-1];
                        shift_d = {shift_q[SAMPLE_W-2:0], 1'b0};
                        if (fall_cnt == CNT_W'(N_BITS - 1)) begin
                            state_d = TAIL;
                        end
                    end else begin
                        sdo_d = 1'b0;
                    end
                end
            end
            default: begin
                state_d  = IDLE;
                sdo_d    = 1'b0;
                sdo_oe_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            shift_q     <= '0;
            fall_cnt    <= '0;
            ramp_q      <= '0;
            load_q      <= '0;
            frame_count <= '0;
            sdo_q       <= 1'b0;
            sdo_oe_q    <= 1'b0;
            frame_done  <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            state       <= state_d;
            shift_q     <= shift_d;
            fall_cnt    <= fall_cnt_d;
            ramp_q      <= ramp_d;
            load_q      <= load_d;
            frame_count <= frame_count_d;
            sdo_q       <= sdo_d;
            sdo_oe_q    <= sdo_oe_d;
            frame_done  <= frame_done_d;
            frame_err   <= frame_err_d;
        end
    end

    assign spi.sdo    = sdo_q;
    assign spi.sdo_oe = sdo_oe_q;

endmodule

// File: tb/tb_ltc2315_sdo_emulator.sv
// Bench for ltc2315_sdo_emulator: two instances share the serial bus, one with
// default parameters and one fixed in ramp mode with a large ramp step so the
// 12-bit ramp wrap is reached within a few frames.
module tb_ltc2315_sdo_emulator;

    localparam logic [11:0] STEP1 = 12'd1000;
    localparam logic [11:0] CVAL  = 12'h800;

    logic        clk = 1'b0;
    logic        reset;
    logic        cs_n_drv;
    logic        sck_drv;
    logic [1:0]  mode;
    logic [11:0] sample_in;
    logic        sample_wr;

    logic        fd0, fe0, fd1, fe1;
    logic [15:0] fc0, fc1;

    ltc2315_sdo_emulator_if bus0 ();
    ltc2315_sdo_emulator_if bus1 ();

    assign bus0.cs_n = cs_n_drv;
    assign bus0.sck  = sck_drv;
    assign bus1.cs_n = cs_n_drv;
    assign bus1.sck  = sck_drv;

    ltc2315_sdo_emulator dut0 (
        .clk         (clk),
        .reset       (reset),
        .spi         (bus0.slave),
        .mode        (mode),
        .sample_in   (sample_in),
        .sample_wr   (sample_wr),
        .frame_done  (fd0),
        .frame_err   (fe0),
        .frame_count (fc0)
    );

    ltc2315_sdo_emulator #(.SYNC_STAGES(3), .RAMP_STEP(STEP1)) dut1 (
        .clk         (clk),
        .reset       (reset),
        .spi         (bus1.slave),
        .mode        (2'b01),
        .sample_in   (sample_in),
        .sample_wr   (sample_wr),
        .frame_done  (fd1),
        .frame_err   (fe1),
        .frame_count (fc1)
    );

    always #10 clk = ~clk;

    int passed = 0;
    int total  = 0;

    // Pulse counters, sampled away from the active edge
    int done0 = 0, err0 = 0, done1 = 0, err1 = 0;
    always @(negedge clk) begin
        if (fd0 === 1'b1) done0++;
        if (fe0 === 1'b1) err0++;
        if (fd1 === 1'b1) done1++;
        if (fe1 === 1'b1) err1++;
    end

    // Reference model state
    logic [11:0] m_ramp0, m_ramp1, m_load;
    logic [15:0] m_count;

    // Bit seen by the master on the k-th sck rise after the frame's k-th fall:
    // position 0 is the leading zero, 1..12 the sample MSB-first, then zeros.
    function automatic logic exp_bit(input logic [11:0] s, input int k);
        if (k >= 1 && k <= 12) return s[12-k];
        return 1'b0;
    endfunction

    task automatic run_frame(input int nfalls, input bit combined,
                             input bit wr_at_fall, input logic [11:0] wr_val,
                             input bit mid_wr, input logic [11:0] mid_val,
                             input bit mid_mode, input logic [1:0] mid_mode_val);
        logic [11:0] exp0, exp1;
        int d0, e0, d1, e1;
        bit valid;
        if (wr_at_fall) m_load = wr_val;
        case (mode)
            2'b01:   exp0 = m_ramp0;
            2'b10:   exp0 = m_load;
            default: exp0 = CVAL;
        endcase
        exp1  = m_ramp1;
        valid = (nfalls >= 12);
        d0 = done0; e0 = err0; d1 = done1; e1 = err1;

        @(negedge clk) cs_n_drv = 1'b0;
        @(negedge clk);
        @(negedge clk);
        if (wr_at_fall) begin
            sample_wr = 1'b1;
            sample_in = wr_val;
        end
        @(negedge clk) sample_wr = 1'b0;
        total++;
        if (bus0.sdo_oe !== 1'b1) $display("FAIL oe_start: got %b want 1", bus0.sdo_oe);
        else passed++;
        @(negedge clk);

        for (int k = 1; k <= nfalls; k++) begin
            sck_drv = 1'b0;
            if (mid_wr && k == 6) begin
                sample_wr = 1'b1;
                sample_in = mid_val;
                m_load    = mid_val;
            end
            if (mid_mode && k == 6) mode = mid_mode_val;
            @(negedge clk) sample_wr = 1'b0;
            @(negedge clk);
            total++;
            if (bus0.sdo !== exp_bit(exp0, k - 1))
                $display("FAIL sdo0 rise %0d sample %h: got %b want %b", k, exp0, bus0.sdo, exp_bit(exp0, k - 1));
            else passed++;
            total++;
            if (bus1.sdo !== exp_bit(exp1, k - 1))
                $display("FAIL sdo1 rise %0d sample %h: got %b want %b", k, exp1, bus1.sdo, exp_bit(exp1, k - 1));
            else passed++;
            sck_drv = 1'b1;
            @(negedge clk);
            @(negedge clk);
        end

        cs_n_drv = 1'b1;
        if (combined) sck_drv = 1'b0;
        if (valid) begin
            m_count = m_count + 16'd1;
            m_ramp0 = m_ramp0 + 12'd1;
            m_ramp1 = m_ramp1 + STEP1;
        end
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        // Outputs one cycle after dut0 sees the cs rise
        total++;
        if (bus0.sdo_oe !== 1'b0 || bus0.sdo !== 1'b0)
            $display("FAIL oe_end: got oe=%b sdo=%b want 0 0", bus0.sdo_oe, bus0.sdo);
        else passed++;
        total++;
        if (fd0 !== valid || fe0 !== !valid)
            $display("FAIL pulse_at_rise: got done=%b err=%b want done=%b", fd0, fe0, valid);
        else passed++;
        sck_drv = 1'b1;
        repeat (4) @(negedge clk);
        total++;
        if ((done0 - d0) != int'(valid) || (err0 - e0) != int'(!valid))
            $display("FAIL pulse_count0: got done=%0d err=%0d want valid=%b", done0 - d0, err0 - e0, valid);
        else passed++;
        total++;
        if ((done1 - d1) != int'(valid) || (err1 - e1) != int'(!valid))
            $display("FAIL pulse_count1: got done=%0d err=%0d want valid=%b", done1 - d1, err1 - e1, valid);
        else passed++;
        total++;
        if (fc0 !== m_count || fc1 !== m_count)
            $display("FAIL frame_count: got %0d/%0d want %0d", fc0, fc1, m_count);
        else passed++;
    endtask

    task automatic write_load(input logic [11:0] v);
        @(negedge clk);
        sample_wr = 1'b1;
        sample_in = v;
        m_load    = v;
        @(negedge clk) sample_wr = 1'b0;
    endtask

    task automatic model_reset();
        m_ramp0 = '0;
        m_ramp1 = '0;
        m_load  = '0;
        m_count = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1; cs_n_drv = 1'b1; sck_drv = 1'b1;
        mode = 2'b00; sample_in = '0; sample_wr = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        total++;
        if (bus0.sdo !== 1'b0 || bus0.sdo_oe !== 1'b0 || fd0 !== 1'b0 || fe0 !== 1'b0)
            $display("FAIL reset_outputs: got sdo=%b oe=%b done=%b err=%b want 0", bus0.sdo, bus0.sdo_oe, fd0, fe0);
        else passed++;
        total++;
        if (fc0 !== 16'd0 || fc1 !== 16'd0)
            $display("FAIL reset_count: got %0d/%0d want 0", fc0, fc1);
        else passed++;
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_idle_sck();
        int e0;
        e0 = err0;
        for (int i = 0; i < 4; i++) begin
            sck_drv = 1'b0;
            repeat (3) @(negedge clk);
            total++;
            if (bus0.sdo_oe !== 1'b0 || bus0.sdo !== 1'b0)
                $display("FAIL idle_sck: got oe=%b sdo=%b want 0 0", bus0.sdo_oe, bus0.sdo);
            else passed++;
            sck_drv = 1'b1;
            repeat (2) @(negedge clk);
        end
        total++;
        if (err0 != e0 || fc0 !== m_count)
            $display("FAIL idle_sck_events: got err=%0d count=%0d want 0 %0d", err0 - e0, fc0, m_count);
        else passed++;
    endtask

    task automatic test_constant();
        mode = 2'b00;
        run_frame(16, 0, 0, '0, 0, '0, 0, '0);
        mode = 2'b11;
        run_frame(16, 0, 0, '0, 0, '0, 0, '0);
    endtask

    task automatic test_ramp();
        mode = 2'b01;
        for (int i = 0; i < 8; i++)
            run_frame(12 + (i % 5), 0, 0, '0, 0, '0, 0, '0);
    endtask

    task automatic test_loaded_bypass();
        write_load(12'h3C3);
        mode = 2'b10;
        run_frame(16, 0, 1, 12'hA5C, 1, 12'h123, 0, '0);
        run_frame(13, 0, 0, '0, 0, '0, 0, '0);
    endtask

    task automatic test_abort();
        mode = 2'b01;
        run_frame(8, 0, 0, '0, 0, '0, 0, '0);
        run_frame(13, 0, 0, '0, 0, '0, 0, '0);
    endtask

    task automatic test_same_cycle();
        mode = 2'b01;
        run_frame(11, 1, 0, '0, 0, '0, 0, '0);
        run_frame(12, 1, 0, '0, 0, '0, 0, '0);
    endtask

    task automatic test_reset_midframe();
        int d0, e0;
        mode = 2'b00;
        d0 = done0; e0 = err0;
        @(negedge clk) cs_n_drv = 1'b0;
        repeat (4) @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            sck_drv = 1'b0;
            repeat (2) @(negedge clk);
            sck_drv = 1'b1;
            repeat (2) @(negedge clk);
        end
        reset = 1'b1; cs_n_drv = 1'b1; sck_drv = 1'b1;
        model_reset();
        @(negedge clk);
        total++;
        if (bus0.sdo_oe !== 1'b0 || fc0 !== 16'd0 || fc1 !== 16'd0)
            $display("FAIL reset_mid: got oe=%b count=%0d/%0d want 0", bus0.sdo_oe, fc0, fc1);
        else passed++;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (6) @(negedge clk);
        total++;
        if (done0 != d0 || err0 != e0)
            $display("FAIL reset_mid_pulses: got done=%0d err=%0d want 0 0", done0 - d0, err0 - e0);
        else passed++;
        run_frame(16, 0, 0, '0, 0, '0, 0, '0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 16; i++) begin
            if ($urandom_range(0, 1) == 1) write_load(12'($urandom));
            mode = 2'($urandom_range(0, 3));
            run_frame($urandom_range(6, 16), bit'($urandom_range(0, 1)),
                      bit'($urandom_range(0, 1)), 12'($urandom),
                      bit'($urandom_range(0, 1)), 12'($urandom),
                      bit'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
        end
    endtask

    initial begin
        test_reset();
        test_idle_sck();
        test_constant();
        test_ramp();
        test_loaded_bypass();
        test_abort();
        test_same_cycle();
        test_reset_midframe();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
